alien_grid_engine: RTL

Parametrised renderer for the invader formation. It holds the alive mask and vertical offset for a ROWS×COLS grid of aliens and executes four commands: draw, kill one alien, step the formation down, and full-screen fill. Each command produces a one-pixel-per-cycle stream (x, y, colour, plot) for the VGA adapter write port. It sits between the game-control FSM (commands) and the shared sprite ROM / VGA plot mux.

---
 rtl/alien_grid_engine.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alien_grid_engine.sv
// alien_grid_engine: holds the invader formation (alive mask, vertical offset)
// and renders DRAW / KILL / STEP / FILL commands as a one-pixel-per-cycle
// stream for the VGA write port. Sprite ROM reads have one cycle of latency,
// so every pixel is issued on sprite_addr in one cycle and appears on
// x/y/colour/plot in the next.
module alien_grid_engine #(
  parameter int COLS     = 5,
  parameter int ROWS     = 1,
  parameter int ALIEN_W  = 12,
  parameter int ALIEN_H  = 10,
  parameter int X0       = 10,
  parameter int Y0       = 10,
  parameter int PITCH_X  = 32,
  parameter int PITCH_Y  = 14,
  parameter int STEP_Y   = 5,
  parameter int Y_LIMIT  = 100,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [1:0]                           cmd_op,
  input  logic [7:0]                           cmd_idx,
  input  logic [2:0]                           fill_colour,
  output logic [$clog2(ALIEN_W*ALIEN_H)-1:0]   sprite_addr,
  input  logic [2:0]                           sprite_data,
  output logic [7:0]                           x,
  output logic [6:0]                           y,
  output logic [2:0]                           colour,
  output logic                                 plot,
  output logic                                 done,
  output logic [ROWS*COLS-1:0]                 alive,
  output logic                                 all_dead,
  output logic                                 reached_limit
);

  localparam int N    = ROWS * COLS;
  localparam int SA_W = $clog2(ALIEN_W * ALIEN_H);

  localparam logic [1:0] OP_DRAW = 2'd0;
  localparam logic [1:0] OP_KILL = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;

  // SCAN picks the next alive alien, RASTER walks its box, FILLSCR walks the
  // whole screen, FLUSH lets the last pixel leave the pipeline, DONE pulses.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_RASTER,
    S_FILLSCR,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [2:0]       fill_q;
  logic [7:0]       k_q;          // alien index being scanned / rastered
  logic             erase_q;      // STEP: high during the erase pass
  logic             kill_q;       // KILL targets a live alien
  logic [7:0]       px_q;
  logic [7:0]       py_q;
  logic [SA_W-1:0]  addr_q;
  logic [7:0]       box_x_q;
  logic [6:0]       box_y_q;
  logic [7:0]       fx_q;
  logic [6:0]       fy_q;
  logic [6:0]       y_off_q;
  logic             limit_pend_q; // invasion result of the current STEP
  logic [N-1:0]     alive_q;
  logic             reached_q;
  logic             ready_q;
  logic             done_q;
  logic             plot_q;
  logic [7:0]       x_q;
  logic [6:0]       y_q;
  logic [2:0]       colour_q;
  logic             use_rom_q;    // pixel on the outputs takes its colour from the ROM

  logic             cur_alive;
  logic             more_alive;
  logic             kill_ok;
  int               low_row;
  int               y_sum;
  logic [6:0]       y_off_d;
  logic             limit_hit;
  logic [N-1:0]     alive_d;
  logic [7:0]       box_x_d;
  logic [6:0]       box_y_d;

  // Formation queries: current/remaining alive aliens, kill target, lowest row, moved offset.
  always_comb begin
    cur_alive  = 1'b0;
    more_alive = 1'b0;
    kill_ok    = 1'b0;
    low_row    = 0;
    alive_d    = alive_q;
    for (int i = 0; i < N; i++) begin
      if (k_q == 8'(i) && alive_q[i]) cur_alive = 1'b1;
      if (int'(k_q) < i && alive_q[i]) more_alive = 1'b1;
      if (cmd_idx == 8'(i) && alive_q[i]) kill_ok = 1'b1;
      if (alive_q[i]) low_row = i / COLS;
      if (k_q == 8'(i)) alive_d[i] = 1'b0;
    end
    y_sum     = int'(y_off_q) + STEP_Y;
    y_off_d   = (y_sum > 127) ? 7'd127 : 7'(y_sum);
    limit_hit = (alive_q != '0) &&
                (Y0 + int'(y_off_d) + low_row * PITCH_Y + ALIEN_H >= Y_LIMIT);
    box_x_d   = 8'(X0 + (int'(k_q) % COLS) * PITCH_X);
    box_y_d   = 7'(Y0 + int'(y_off_q) + (int'(k_q) / COLS) * PITCH_Y);
  end

  // Command FSM with registered pixel outputs and formation state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_DRAW;
      fill_q       <= 3'd0;
      k_q          <= 8'd0;
      erase_q      <= 1'b0;
      kill_q       <= 1'b0;
      px_q         <= 8'd0;
      py_q         <= 8'd0;
      addr_q       <= '0;
      box_x_q      <= 8'd0;
      box_y_q      <= 7'd0;
      fx_q         <= 8'd0;
      fy_q         <= 7'd0;
      y_off_q      <= 7'd0;
      limit_pend_q <= 1'b0;
      alive_q      <= '1;
      reached_q    <= 1'b0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      colour_q     <= 3'd0;
      use_rom_q    <= 1'b0;
    end else begin
      plot_q    <= 1'b0;
      done_q    <= 1'b0;
      use_rom_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
          if (cmd_valid) begin
            ready_q      <= 1'b0;
            op_q         <= cmd_op;
            fill_q       <= fill_colour;
            limit_pend_q <= 1'b0;
            kill_q       <= 1'b0;
            erase_q      <= 1'b0;
            k_q          <= 8'd0;
            case (cmd_op)
              OP_DRAW: state_q <= (alive_q != '0) ? S_SCAN : S_FLUSH;
              OP_KILL: begin
                k_q     <= cmd_idx;
                kill_q  <= kill_ok;
                state_q <= kill_ok ? S_SCAN : S_FLUSH;
              end
              OP_STEP: begin
                if (alive_q != '0) begin
                  erase_q <= 1'b1;
                  state_q <= S_SCAN;
                end else begin
                  // Nothing to erase or redraw, but the formation still moves.
                  y_off_q <= y_off_d;
                  state_q <= S_FLUSH;
                end
              end
              default: begin
                fx_q    <= 8'd0;
                fy_q    <= 7'd0;
                state_q <= S_FILLSCR;
              end
            endcase
          end
        end
        S_SCAN: begin
          if (cur_alive) begin
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            px_q    <= 8'd0;
            py_q    <= 8'd0;
            addr_q  <= '0;
            state_q <= S_RASTER;
          end else begin
            k_q <= k_q + 8'd1;
          end
        end
        S_RASTER: begin
          plot_q    <= 1'b1;
          x_q       <= box_x_q + px_q;
          y_q       <= box_y_q + py_q[6:0];
          colour_q  <= 3'd0;
          use_rom_q <= !erase_q && (op_q != OP_KILL);
          if (px_q == 8'(ALIEN_W - 1)) begin
            px_q <= 8'd0;
            if (py_q == 8'(ALIEN_H - 1)) begin
              py_q   <= 8'd0;
              addr_q <= '0;
              if (op_q == OP_KILL) begin
                state_q <= S_FLUSH;
              end else if (more_alive) begin
                k_q     <= k_q + 8'd1;
                state_q <= S_SCAN;
              end else if (erase_q) begin
                // Erase pass finished: move down and start the redraw pass.
                erase_q      <= 1'b0;
                y_off_q      <= y_off_d;
                limit_pend_q <= limit_hit;
                k_q          <= 8'd0;
                state_q      <= S_SCAN;
              end else begin
                state_q <= S_FLUSH;
              end
            end else begin
              py_q   <= py_q + 8'd1;
              addr_q <= addr_q + 1'b1;
            end
          end else begin
            px_q   <= px_q + 8'd1;
            addr_q <= addr_q + 1'b1;
          end
        end
        S_FILLSCR: begin
          plot_q   <= 1'b1;
          x_q      <= fx_q;
          y_q      <= fy_q;
          colour_q <= fill_q;
          if (fx_q == 8'(SCREEN_W - 1)) begin
            fx_q <= 8'd0;
            if (fy_q == 7'(SCREEN_H - 1)) begin
              fy_q    <= 7'd0;
              state_q <= S_FLUSH;
            end else begin
              fy_q <= fy_q + 7'd1;
            end
          end else begin
            fx_q <= fx_q + 8'd1;
          end
        end
        S_FLUSH: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          if (op_q == OP_KILL && kill_q) alive_q <= alive_d;
          if (op_q == OP_STEP) reached_q <= reached_q | limit_pend_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = ready_q;
  assign sprite_addr   = addr_q;
  assign x             = x_q;
  assign y             = y_q;
  assign colour        = use_rom_q ? sprite_data : colour_q;
  assign plot          = plot_q;
  assign done          = done_q;
  assign alive         = alive_q;
  assign all_dead      = (alive_q == '0);
  assign reached_limit = reached_q;

endmodule
